// File: rtl/mux_scan_n.sv
// N:1 single-bit multiplexer with a registered output and a scan mode.
// The scan mode serialises a captured input word channel by channel.
module mux_scan_n #(
    parameter int SEL_W = 4,
    parameter int DWELL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [(2**SEL_W)-1:0]   In,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    start,
    input  logic                    dir,
    input  logic                    abort,
    output logic                    Y,
    output logic                    Y_L,
    output logic [SEL_W-1:0]        ch,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    localparam int N     = 2**SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] PTR_MAX  = SEL_W'(N - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t             state;
    logic [N-1:0]       shadow;
    logic [SEL_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic               dir_r;
    logic               last_ch;
    logic               last_cyc;

    function automatic logic [SEL_W-1:0] ptr_step(input logic [SEL_W-1:0] p,
                                                  input logic down);
        return down ? (p - SEL_W'(1)) : (p + SEL_W'(1));
    endfunction

    // The final channel depends on the direction latched at start.
    assign last_ch  = dir_r ? (ptr == '0) : (ptr == PTR_MAX);
    assign last_cyc = (cnt == CNT_LAST);

    assign Y_L = ~Y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            Y      <= 1'b0;
            ch     <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            shadow <= '0;
            ptr    <= '0;
            cnt    <= '0;
            dir_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (!mode) begin
                        Y     <= In[sel];
                        ch    <= sel;
                        valid <= 1'b1;
                    end else if (start) begin
                        shadow <= In;
                        ptr    <= dir ? PTR_MAX : '0;
                        cnt    <= '0;
                        dir_r  <= dir;
                        state  <= SCAN;
                        busy   <= 1'b1;
                        valid  <= 1'b0;
                    end else begin
                        valid <= 1'b0;
                    end
                end
                SCAN: begin
                    // Abort outranks completion, so a coinciding abort never pulses done.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                    end else begin
                        Y     <= shadow[ptr];
                        ch    <= ptr;
                        valid <= (cnt == '0);
                        if (last_cyc) begin
                            cnt <= '0;
                            if (last_ch) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                ptr <= ptr_step(ptr, dir_r);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: a DWELL=1 instance and a DWELL=3 instance.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] in_w;
    logic [3:0]  sel;
    logic        mode, start, dir, abort;
    logic        y, y_l, valid, busy, done;
    logic [3:0]  ch;

    logic [15:0] in3;
    logic [3:0]  sel3;
    logic        mode3, start3, dir3, abort3;
    logic        y3, y_l3, valid3, busy3, done3;
    logic [3:0]  ch3;

    typedef struct packed {
        logic [3:0] ch;
        logic       y;
        logic       d;
    } exp_t;

    exp_t q[$];
    exp_t q3[$];

    int vectors = 0;
    int miscompares = 0;

    // Hand-derived bit sequences of 16'hC3B4 in presentation order.
    bit up_exp[16]   = '{0,0,1,0,1,1,0,1,1,1,0,0,0,0,1,1};
    bit down_exp[16] = '{1,1,0,0,0,0,1,1,1,0,1,1,0,1,0,0};

    always #5 clk = ~clk;

    mux_scan_n #(.SEL_W(4), .DWELL(1)) u1 (
        .clk(clk), .reset(reset), .In(in_w), .sel(sel), .mode(mode),
        .start(start), .dir(dir), .abort(abort), .Y(y), .Y_L(y_l),
        .ch(ch), .valid(valid), .busy(busy), .done(done)
    );

    mux_scan_n #(.SEL_W(4), .DWELL(3)) u3 (
        .clk(clk), .reset(reset), .In(in3), .sel(sel3), .mode(mode3),
        .start(start3), .dir(dir3), .abort(abort3), .Y(y3), .Y_L(y_l3),
        .ch(ch3), .valid(valid3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int c, input bit b, input bit d);
        exp_t e;
        e.ch = 4'(c);
        e.y  = b;
        e.d  = d;
        return e;
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL u1 unexpected sample: ch=%0d y=%0b, required no sample", ch, y);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("u1 ch", 32'(ch), 32'(e.ch));
                chk("u1 y", 32'(y), 32'(e.y));
                chk("u1 y_l", 32'(y_l), 32'(!e.y));
                chk("u1 done at sample", 32'(done), 32'(e.d));
            end
        end
    end

    always @(negedge clk) begin
        if (valid3) begin
            if (q3.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL u3 unexpected sample: ch=%0d y=%0b, required no sample", ch3, y3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("u3 ch", 32'(ch3), 32'(e.ch));
                chk("u3 y", 32'(y3), 32'(e.y));
                chk("u3 y_l", 32'(y_l3), 32'(!e.y));
                chk("u3 done at sample", 32'(done3), 32'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " y"}, 32'(y), 32'(0));
        chk({tag, " y_l"}, 32'(y_l), 32'(1));
        chk({tag, " ch"}, 32'(ch), 32'(0));
        chk({tag, " valid"}, 32'(valid), 32'(0));
        chk({tag, " busy"}, 32'(busy), 32'(0));
        chk({tag, " done"}, 32'(done), 32'(0));
    endtask

    task automatic run_up(input string tag);
        in_w  = 16'hC3B4;
        dir   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 16; i++) q.push_back(mk(i, up_exp[i], i == 15));
        tick();
        start = 1'b0;
        chk({tag, " E0 busy"}, 32'(busy), 32'(1));
        chk({tag, " E0 valid"}, 32'(valid), 32'(0));
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk({tag, " busy"}, 32'(busy), 32'(k < 16));
            chk({tag, " done"}, 32'(done), 32'(k == 16));
        end
        tick();
        chk({tag, " done clears"}, 32'(done), 32'(0));
        chk({tag, " valid after"}, 32'(valid), 32'(0));
    endtask

    initial begin
        int vcount;
        int dcount;
        reset = 1'b1;
        in_w = 16'h0; sel = 4'd0; mode = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
        in3 = 16'h0; sel3 = 4'd0; mode3 = 1'b1; start3 = 1'b0; dir3 = 1'b0; abort3 = 1'b0;
        #2;
        chk_reset_state("power-on");
        chk("power-on u3 y_l", 32'(y_l3), 32'(1));
        chk("power-on u3 busy", 32'(busy3), 32'(0));
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Manual mode sweep
        in_w = 16'hC3B4;
        mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            q.push_back(mk(i, up_exp[i], 1'b0));
            tick();
        end
        in_w = 16'hCFFF;
        sel  = 4'd4;
        q.push_back(mk(4, 1'b1, 1'b0));
        tick();
        mode = 1'b1;
        tick();
        chk("manual exit valid", 32'(valid), 32'(0));
        chk("manual exit y hold", 32'(y), 32'(1));
        chk("manual exit ch hold", 32'(ch), 32'(4));

        run_up("scan up");

        // Scan down, input changed after capture, second start ignored
        in_w  = 16'hC3B4;
        dir   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 16; i++) q.push_back(mk(15 - i, down_exp[i], i == 15));
        tick();
        start = 1'b0;
        in_w  = 16'h0000;
        dir   = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            start = (k == 8);
            tick();
            chk("scan down busy", 32'(busy), 32'(k < 16));
            chk("scan down done", 32'(done), 32'(k == 16));
        end
        start = 1'b0;
        tick();
        chk("scan down no restart", 32'(busy), 32'(0));

        // Abort at k=5
        in_w  = 16'hC3B4;
        dir   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 16; i++) q.push_back(mk(i, up_exp[i], i == 15));
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'(0));
        chk("abort valid", 32'(valid), 32'(0));
        chk("abort done", 32'(done), 32'(0));
        chk("abort ch hold", 32'(ch), 32'(3));
        chk("abort y hold", 32'(y), 32'(up_exp[3]));
        q.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post-abort done", 32'(done), 32'(0));
            chk("post-abort busy", 32'(busy), 32'(0));
        end
        run_up("post-abort scan");

        // Asynchronous reset mid-scan
        in_w  = 16'hC3B4;
        dir   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 16; i++) q.push_back(mk(i, up_exp[i], i == 15));
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        #1;
        reset = 1'b1;
        #1;
        chk_reset_state("async reset");
        q.delete();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_reset_state("after release");
        end

        // DWELL=3 instance
        in3    = 16'h0001;
        dir3   = 1'b0;
        start3 = 1'b1;
        for (int i = 0; i < 16; i++) q3.push_back(mk(i, i == 0, 1'b0));
        tick();
        start3 = 1'b0;
        chk("dwell E0 busy", 32'(busy3), 32'(1));
        vcount = 0;
        dcount = 0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            chk("dwell y", 32'(y3), 32'(k <= 3));
            chk("dwell valid", 32'(valid3), 32'(((k - 1) % 3) == 0));
            chk("dwell busy", 32'(busy3), 32'(k < 48));
            chk("dwell done", 32'(done3), 32'(k == 48));
            vcount += int'(valid3);
            dcount += int'(done3);
        end
        tick();
        dcount += int'(done3);
        chk("dwell valid pulses", 32'(vcount), 32'(16));
        chk("dwell done pulses", 32'(dcount), 32'(1));

        tick();
        tick();
        chk("u1 queue drained", 32'(q.size()), 32'(0));
        chk("u3 queue drained", 32'(q3.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
